// File: rtl/muldiv_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_div_ctrl
//  Description : Issue/writeback controller around the execute-stage divider,
//                with a one-entry quotient/remainder result cache.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_div_ctrl #(
  parameter int XLEN    = 32,
  parameter int FUSE_EN = 1
) (
  input  logic            clk,
  input  logic            cpurst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [4:0]      req_rd,
  input  logic            flush,
  output logic [XLEN-1:0] div_dividend,
  output logic [XLEN-1:0] div_divider,
  output logic            div_signed,
  output logic            div_start_p,
  input  logic            div_done,
  input  logic [XLEN-1:0] div_quo,
  input  logic [XLEN-1:0] div_rem,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data
);

  localparam logic c_fuse = (FUSE_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [XLEN-1:0] r_rs1;
  logic [XLEN-1:0] r_rs2;
  logic [4:0]      r_rd;
  logic            r_is_rem;
  logic            r_signed;
  logic [XLEN-1:0] r_wb_data;

  logic            r_c_vld;
  logic [XLEN-1:0] r_c_rs1;
  logic [XLEN-1:0] r_c_rs2;
  logic            r_c_signed;
  logic [XLEN-1:0] r_c_quo;
  logic [XLEN-1:0] r_c_rem;

  logic            w_req_ready;
  logic            w_start_p;
  logic            w_wb_valid;
  logic            w_accept;
  logic            w_hit;
  logic            w_done_cap;

  assign w_accept = req_valid & (r_state == S_IDLE) & ~flush;

  // The signed flag is part of the match: DIVU and REM on equal bits differ.
  assign w_hit = c_fuse & r_c_vld
               & (req_rs1 == r_c_rs1)
               & (req_rs2 == r_c_rs2)
               & (~req_op[0] == r_c_signed);

  assign w_done_cap = div_done & ((r_state == S_WAIT) | (r_state == S_DRAIN));

  always_ff @(posedge clk or negedge cpurst) begin
    if (!cpurst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = 1'b0;
    w_start_p   = 1'b0;
    w_wb_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req_ready = 1'b1;
        if (w_accept) begin
          w_state_nxt = w_hit ? S_RESP : S_START;
        end
      end
      S_START: begin
        w_start_p   = 1'b1;
        w_state_nxt = flush ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (div_done) begin
          w_state_nxt = flush ? S_IDLE : S_RESP;
        end else if (flush) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_RESP: begin
        w_wb_valid = 1'b1;
        if (flush || wb_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DRAIN: begin
        // The divider cannot be aborted; wait for it to finish quietly.
        if (div_done) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge cpurst) begin
    if (!cpurst) begin
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_rd      <= '0;
      r_is_rem  <= 1'b0;
      r_signed  <= 1'b0;
      r_wb_data <= '0;
    end else if (w_accept) begin
      r_rs1    <= req_rs1;
      r_rs2    <= req_rs2;
      r_rd     <= req_rd;
      r_is_rem <= req_op[1];
      r_signed <= ~req_op[0];
      if (w_hit) begin
        r_wb_data <= req_op[1] ? r_c_rem : r_c_quo;
      end
    end else if (w_done_cap && (r_state == S_WAIT)) begin
      r_wb_data <= r_is_rem ? div_rem : div_quo;
    end
  end

  // A drained result still refills the cache so a retried op can hit.
  always_ff @(posedge clk or negedge cpurst) begin
    if (!cpurst) begin
      r_c_vld    <= 1'b0;
      r_c_rs1    <= '0;
      r_c_rs2    <= '0;
      r_c_signed <= 1'b0;
      r_c_quo    <= '0;
      r_c_rem    <= '0;
    end else if (w_done_cap) begin
      r_c_vld    <= 1'b1;
      r_c_rs1    <= r_rs1;
      r_c_rs2    <= r_rs2;
      r_c_signed <= r_signed;
      r_c_quo    <= div_quo;
      r_c_rem    <= div_rem;
    end
  end

  assign req_ready    = w_req_ready;
  assign div_start_p  = w_start_p;
  assign div_dividend = r_rs1;
  assign div_divider  = r_rs2;
  assign div_signed   = r_signed;
  assign wb_valid     = w_wb_valid;
  assign wb_rd        = r_rd;
  assign wb_data      = r_wb_data;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_div_ctrl
//  Description : Scoreboard bench for muldiv_div_ctrl with a divider model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_div_ctrl;

  logic        clk;
  logic        cpurst;
  logic        req_valid;
  logic        nf_req_valid;
  logic [1:0]  req_op;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic [4:0]  req_rd;
  logic        flush;
  logic        div_done;
  logic [31:0] div_quo;
  logic [31:0] div_rem;
  logic        wb_ready;

  logic        req_ready,    nf_req_ready;
  logic [31:0] div_dividend, nf_dividend;
  logic [31:0] div_divider,  nf_divider;
  logic        div_signed,   nf_signed;
  logic        div_start_p,  nf_start_p;
  logic        wb_valid,     nf_wb_valid;
  logic [4:0]  wb_rd,        nf_wb_rd;
  logic [31:0] wb_data,      nf_wb_data;

  muldiv_div_ctrl #(.XLEN(32), .FUSE_EN(1)) u_dut (
    .clk(clk), .cpurst(cpurst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd), .flush(flush),
    .div_dividend(div_dividend), .div_divider(div_divider),
    .div_signed(div_signed), .div_start_p(div_start_p),
    .div_done(div_done), .div_quo(div_quo), .div_rem(div_rem),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  muldiv_div_ctrl #(.XLEN(32), .FUSE_EN(0)) u_nofuse (
    .clk(clk), .cpurst(cpurst),
    .req_valid(nf_req_valid), .req_ready(nf_req_ready), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd), .flush(flush),
    .div_dividend(nf_dividend), .div_divider(nf_divider),
    .div_signed(nf_signed), .div_start_p(nf_start_p),
    .div_done(div_done), .div_quo(div_quo), .div_rem(div_rem),
    .wb_valid(nf_wb_valid), .wb_ready(wb_ready), .wb_rd(nf_wb_rd), .wb_data(nf_wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_start = 0;
  int nf_start = 0;

  typedef struct packed { logic [4:0] rd; logic [31:0] data; } wb_t;
  wb_t sb_q[$];

  // divider model controls
  int          bfm_lat = 4;
  logic [31:0] bfm_q, bfm_r;
  bit          bfm_busy = 0;
  bit          bfm_exp_resp = 0;
  bit          bfm_chk_ops = 0;
  logic [31:0] exp_rs1, exp_rs2;
  logic        exp_sgn;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  task automatic fail_timeout(string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out waiting, got no event, expected one", name);
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] data);
    wb_t e;
    e.rd = rd;
    e.data = data;
    sb_q.push_back(e);
  endtask

  task automatic set_ops(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_rs1 = a;
    exp_rs2 = b;
    exp_sgn = s;
  endtask

  task automatic issue(input bit nf, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    int t = 0;
    @(posedge clk); #1;
    while (!(nf ? nf_req_ready : req_ready)) begin
      t++;
      if (t > 100) begin
        fail_timeout("issue_ready");
        return;
      end
      @(posedge clk); #1;
    end
    req_op = op; req_rs1 = a; req_rs2 = b; req_rd = rd;
    if (nf) nf_req_valid = 1'b1; else req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    nf_req_valid = 1'b0;
  endtask

  task automatic wait_wb(input bit nf, input string name);
    int t = 0;
    @(negedge clk);
    while (!(nf ? nf_wb_valid : wb_valid)) begin
      t++;
      if (t > 50) begin
        fail_timeout(name);
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input bit nf);
    int t = 0;
    @(posedge clk); #1;
    while (!(nf ? nf_req_ready : req_ready) || bfm_busy) begin
      t++;
      if (t > 100) begin
        fail_timeout("wait_idle");
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_req_ready"},   req_ready,    1);
    check({tag, "_start_p"},     div_start_p,  0);
    check({tag, "_wb_valid"},    wb_valid,     0);
    check({tag, "_dividend"},    div_dividend, 0);
    check({tag, "_divider"},     div_divider,  0);
    check({tag, "_signed"},      div_signed,   0);
    check({tag, "_wb_rd"},       wb_rd,        0);
    check({tag, "_wb_data"},     wb_data,      0);
  endtask

  // start-pulse counters
  initial forever begin
    @(negedge clk);
    if (cpurst && div_start_p) n_start++;
    if (cpurst && nf_start_p)  nf_start++;
  end

  // divider model: returns preloaded quo/rem bfm_lat cycles after a start
  initial begin
    div_done = 1'b0;
    div_quo  = '0;
    div_rem  = '0;
    forever begin
      @(negedge clk);
      if (div_start_p || nf_start_p) begin
        bfm_busy = 1;
        repeat (bfm_lat) @(posedge clk);
        #1;
        div_done = 1'b1;
        div_quo  = bfm_q;
        div_rem  = bfm_r;
        @(negedge clk);
        if (bfm_chk_ops) begin
          check("ops_dividend", div_dividend, exp_rs1);
          check("ops_divider",  div_divider,  exp_rs2);
          check("ops_signed",   div_signed,   exp_sgn);
        end
        @(posedge clk); #1;
        div_done = 1'b0;
        bfm_busy = 0;
        if (bfm_exp_resp) begin
          @(negedge clk);
          check("miss_latency", wb_valid, 1);
        end
      end
    end
  end

  // scoreboard monitor: every cycle wb_valid is high must match the head entry
  initial forever begin
    @(negedge clk);
    if (cpurst && wb_valid) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_wb: got wb_valid rd=%0d data=%h, expected no response", wb_rd, wb_data);
      end else begin
        check("wb_rd",   wb_rd,   sb_q[0].rd);
        check("wb_data", wb_data, sb_q[0].data);
        if (wb_ready) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no end of test, expected $finish");
    $fatal(1);
  end

  initial begin
    int s0;
    int t;
    cpurst = 1'b0; req_valid = 1'b0; nf_req_valid = 1'b0; flush = 1'b0;
    req_op = '0; req_rs1 = '0; req_rs2 = '0; req_rd = '0; wb_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outs("reset");
    cpurst = 1'b1;

    // DIVU 100/7 with writeback back-pressure
    bfm_q = 32'd14; bfm_r = 32'd2; bfm_lat = 4; bfm_exp_resp = 1; bfm_chk_ops = 1;
    set_ops(32'd100, 32'd7, 1'b0);
    wb_ready = 1'b0;
    s0 = n_start;
    push(5'd5, 32'd14);
    issue(0, 2'd1, 32'd100, 32'd7, 5'd5);
    @(negedge clk);
    check("t1_start", div_start_p, 1);
    check("t1_signed", div_signed, 0);
    @(negedge clk);
    check("t1_start_one_cycle", div_start_p, 0);
    wait_wb(0, "t1_wb");
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    wb_ready = 1'b1;
    wait_idle(0);
    check("t1_start_count", n_start - s0, 1);

    // DIV -7/2 then REM -7/2: second hits the cache
    bfm_q = 32'hFFFF_FFFD; bfm_r = 32'hFFFF_FFFF;
    set_ops(32'hFFFF_FFF9, 32'd2, 1'b1);
    push(5'd6, 32'hFFFF_FFFD);
    issue(0, 2'd0, 32'hFFFF_FFF9, 32'd2, 5'd6);
    wait_wb(0, "t2_div_wb");
    wait_idle(0);
    s0 = n_start;
    push(5'd7, 32'hFFFF_FFFF);
    issue(0, 2'd2, 32'hFFFF_FFF9, 32'd2, 5'd7);
    @(negedge clk);
    check("t2_hit_latency", wb_valid, 1);
    check("t2_hit_no_start", div_start_p, 0);
    wait_idle(0);
    check("t2_hit_start_count", n_start - s0, 0);

    // DIV 0x1234/0, then REMU same bits: signed differs so it misses
    bfm_q = 32'hFFFF_FFFF; bfm_r = 32'h0000_1234;
    set_ops(32'h1234, 32'd0, 1'b1);
    push(5'd8, 32'hFFFF_FFFF);
    issue(0, 2'd0, 32'h1234, 32'd0, 5'd8);
    wait_wb(0, "t3_div_wb");
    wait_idle(0);
    set_ops(32'h1234, 32'd0, 1'b0);
    s0 = n_start;
    push(5'd9, 32'h0000_1234);
    issue(0, 2'd3, 32'h1234, 32'd0, 5'd9);
    @(negedge clk);
    check("t3_signed_miss_start", div_start_p, 1);
    check("t3_unsigned", div_signed, 0);
    wait_wb(0, "t3_remu_wb");
    wait_idle(0);
    check("t3_start_count", n_start - s0, 1);

    // flush in WAIT: drain without writeback, cache still refilled
    bfm_q = 32'd10; bfm_r = 32'd0; bfm_lat = 8; bfm_exp_resp = 0;
    set_ops(32'd50, 32'd5, 1'b1);
    issue(0, 2'd0, 32'd50, 32'd5, 5'd10);
    repeat (3) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("t4_drain_not_ready", req_ready, 0);
    t = 0;
    while (!div_done && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!div_done) fail_timeout("t4_drain_done");
    check("t4_ready_at_done", req_ready, 0);
    @(negedge clk);
    check("t4_ready_after_done", req_ready, 1);
    bfm_lat = 4;
    push(5'd11, 32'd0);
    issue(0, 2'd2, 32'd50, 32'd5, 5'd11);
    @(negedge clk);
    check("t4_hit_latency", wb_valid, 1);
    check("t4_hit_no_start", div_start_p, 0);
    wait_idle(0);

    // reset during WAIT, then a late div_done
    bfm_q = 32'd3; bfm_r = 32'd0; bfm_lat = 8; bfm_chk_ops = 0;
    issue(0, 2'd1, 32'd9, 32'd3, 5'd12);
    repeat (3) @(posedge clk);
    #1;
    cpurst = 1'b0;
    #2;
    check_reset_outs("midrst");
    repeat (2) @(posedge clk);
    #1;
    cpurst = 1'b1;
    t = 0;
    while (bfm_busy && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (bfm_busy) fail_timeout("t5_late_done");
    repeat (3) begin
      @(negedge clk);
      check("t5_late_done_no_wb", wb_valid, 0);
      check("t5_late_done_ready", req_ready, 1);
    end
    bfm_q = 32'd10; bfm_r = 32'd0; bfm_lat = 4; bfm_exp_resp = 1; bfm_chk_ops = 1;
    set_ops(32'd50, 32'd5, 1'b1);
    push(5'd13, 32'd0);
    issue(0, 2'd2, 32'd50, 32'd5, 5'd13);
    @(negedge clk);
    check("t5_post_reset_miss", div_start_p, 1);
    wait_wb(0, "t5_wb");
    wait_idle(0);

    // FUSE_EN=0: same-operand DIV/REM pair both go to the divider
    bfm_q = 32'hFFFF_FFFD; bfm_r = 32'hFFFF_FFFF; bfm_exp_resp = 0; bfm_chk_ops = 0;
    s0 = nf_start;
    issue(1, 2'd0, 32'hFFFF_FFF9, 32'd2, 5'd14);
    wait_wb(1, "t6_div_wb");
    check("t6_div_data", nf_wb_data, 32'hFFFF_FFFD);
    check("t6_div_rd", nf_wb_rd, 5'd14);
    wait_idle(1);
    issue(1, 2'd2, 32'hFFFF_FFF9, 32'd2, 5'd15);
    @(negedge clk);
    check("t6_nofuse_start", nf_start_p, 1);
    wait_wb(1, "t6_rem_wb");
    check("t6_rem_data", nf_wb_data, 32'hFFFF_FFFF);
    check("t6_rem_rd", nf_wb_rd, 5'd15);
    wait_idle(1);
    check("t6_start_count", nf_start - s0, 2);

    check("sb_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
